pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the 5-stage core. It sits at the head of the pipeline and is the consumer of the target PCs produced in decode/execute. It holds the architectural fetch PC and issues fetch requests to instruction memory with a ready handshake. It applies branch and jump redirects, stalls on hazard requests, and signals a pipeline flush of configurable length after every redirect.

## Interface
Parameters:
- DATA_W, 16, width of all PC/address signals
- RESET_PC, 0, PC loaded on reset (must be 4-byte aligned)
- FLUSH_CYCLES, 1, cycles `flush` stays high after a redirect (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hazard unit request to hold the PC
- branch_taken  in  1  resolved conditional branch is taken this cycle
- branch_pc  in  DATA_W  branch target
- jump  in  1  unconditional jump this cycle
- jump_pc  in  DATA_W  jump target
- imem_ready  in  1  instruction memory accepts the request this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  DATA_W  fetch address (= current_pc)
- current_pc  out  DATA_W  registered fetch PC
- updated_pc  out  DATA_W  current_pc + 4, combinational
- fetch_valid  out  1  instruction for fetch_pc returns this cycle
- fetch_pc  out  DATA_W  PC of the instruction qualified by fetch_valid
- flush  out  1  downstream stages must squash their contents

## Operation
- States: BOOT, FETCH, HOLD, FLUSH. Reset state is BOOT.
- Redirect = branch_taken | jump. Target = jump_pc if jump, else branch_pc (jump has priority). Redirect has priority over stall and over a pending fetch.
- BOOT: imem_req=0.
  - Redirect → FLUSH.
  - Otherwise → FETCH next cycle.
- FETCH: imem_req=1.
  - Redirect → FLUSH. current_pc ← target. Counter ← FLUSH_CYCLES. A fetch accepted in this cycle is discarded: no fetch_valid follows it.
  - Otherwise, stall → HOLD. current_pc is held, and no accept occurs even if imem_ready=1.
  - Otherwise, if imem_ready=1 (accept): current_pc ← updated_pc; fetch_valid=1 next cycle with fetch_pc = the accepted address.
  - imem_ready=0: current_pc and imem_addr are held; the request stays asserted.
- HOLD: imem_req=0; current_pc held.
  - Redirect → FLUSH.
  - !stall → FETCH.
- FLUSH: imem_req=0; flush=1.
  - Counter decrements each cycle.
  - A redirect in FLUSH reloads the target and restarts the counter at FLUSH_CYCLES.
  - When counter==1 and no redirect: → HOLD if stall, else → FETCH.
- Arithmetic: updated_pc = current_pc + 4, modulo 2^DATA_W. 0xFFFC wraps to 0x0000 at DATA_W=16; no overflow flag. Targets are taken unmodified; alignment is the producer's responsibility.
- Counter width: clog2(FLUSH_CYCLES+1).

## Timing
- Reset values (the cycle after rst is sampled high): state=BOOT, current_pc=RESET_PC, imem_req=0, fetch_valid=0, fetch_pc=0, flush=0, counter=0.
- rst takes effect at any state, including mid-FLUSH or with a fetch outstanding. No fetch_valid follows a reset.
- Fetch latency: accept at edge N gives fetch_valid=1 in cycle N+1, high for exactly one cycle per accept.
- Back-to-back throughput: one accept per cycle while in FETCH with imem_ready=1 and stall=0.
- Redirect latency: redirect sampled at edge N gives current_pc=target and flush=1 from cycle N+1, for FLUSH_CYCLES cycles. The first request to the target is in cycle N+1+FLUSH_CYCLES.
- fetch_valid is 0 in every cycle where flush=1.
- stall asserted at edge N makes imem_req=0 from cycle N+1. Deasserting at edge M makes imem_req=1 in cycle M+1.
- stall and redirect in the same cycle: redirect wins. stall is honored after FLUSH ends.
- jump and branch_taken in the same cycle: jump_pc is used.

## Test plan
- Reset, RESET_PC=0x0040, imem_ready=1 → one BOOT cycle with imem_req=0. Then imem_addr = 0x0040, 0x0044, 0x0048 on consecutive cycles; fetch_valid each following cycle with matching fetch_pc.
- In FETCH at 0x0044, imem_ready=0 for 3 cycles → imem_addr held at 0x0044, imem_req=1, fetch_valid=0. Accept on the 4th cycle gives fetch_pc=0x0044 one cycle later.
- FLUSH_CYCLES=2, branch_taken with branch_pc=0x0100 while a fetch is accepted → current_pc=0x0100 next cycle. flush=1 and imem_req=0 for 2 cycles, and the discarded fetch produces no fetch_valid. Then imem_addr=0x0100.
- jump=1, jump_pc=0x0200, branch_taken=1, branch_pc=0x0300, stall=1, all simultaneous → target 0x0200. A second redirect to 0x0400 during FLUSH restarts the counter. After FLUSH the unit enters HOLD while stall=1 and fetches 0x0400 after stall drops.
- current_pc=0xFFFC (DATA_W=16), accept → updated_pc=0x0000 and the next imem_addr is 0x0000.
- rst asserted in the 1st FLUSH cycle of a 3-cycle flush → next cycle: flush=0, current_pc=RESET_PC, state BOOT, fetch_valid=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and instruction-fetch sequencer at the head of the
//   5-stage pipeline. It holds the fetch PC, issues fetch requests to
//   instruction memory with a ready handshake, applies branch/jump
//   redirects, holds on hazard stalls, and raises a flush of FLUSH_CYCLES
//   cycles after every redirect.
//
// Parameters
//   DATA_W       width of all PC/address signals
//   RESET_PC     PC loaded on reset (4-byte aligned)
//   FLUSH_CYCLES cycles flush stays high after a redirect (>= 1)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hazard request to hold the PC
//   branch_taken, branch_pc  taken conditional branch and its target
//   jump, jump_pc            unconditional jump and its target (wins over branch)
//   imem_ready               instruction memory accepts the request this cycle
//   imem_req, imem_addr      fetch request valid and its address (= current_pc)
//   current_pc               registered fetch PC
//   updated_pc               current_pc + 4 (combinational, wraps)
//   fetch_valid, fetch_pc    instruction for fetch_pc returns this cycle
//   flush                    downstream stages must squash their contents
module pc_fetch_unit #(
    parameter int unsigned          DATA_W       = 16,
    parameter logic [DATA_W-1:0]    RESET_PC     = '0,
    parameter int unsigned          FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_pc,
    input  logic              jump,
    input  logic [DATA_W-1:0] jump_pc,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    output logic [DATA_W-1:0] current_pc,
    output logic [DATA_W-1:0] updated_pc,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_pc,
    output logic              flush
);

    localparam int unsigned   CW         = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic              redirect;
    logic [DATA_W-1:0] target;
    logic              accept;

    assign updated_pc = current_pc + DATA_W'(4);
    assign imem_addr  = current_pc;

    always_comb begin
        redirect = branch_taken | jump;
        target   = jump ? jump_pc : branch_pc;
        // Redirect and stall both block the handshake, so a fetch that
        // memory happens to accept in a redirect cycle is simply dropped.
        accept   = (state == S_FETCH) && !redirect && !stall && imem_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BOOT;
            current_pc  <= RESET_PC;
            imem_req    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            flush       <= 1'b0;
            count       <= '0;
        end else begin
            fetch_valid <= accept;
            if (accept) begin
                fetch_pc   <= current_pc;
                current_pc <= updated_pc;
            end

            if (redirect) begin
                // Any state, including FLUSH itself, reloads target and counter.
                state      <= S_FLUSH;
                current_pc <= target;
                count      <= FLUSH_LOAD;
                imem_req   <= 1'b0;
                flush      <= 1'b1;
            end else begin
                case (state)
                    S_BOOT: begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                    S_FETCH: begin
                        if (stall) begin
                            state    <= S_HOLD;
                            imem_req <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            flush <= 1'b0;
                            if (stall) begin
                                state    <= S_HOLD;
                                imem_req <= 1'b0;
                            end else begin
                                state    <= S_FETCH;
                                imem_req <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= S_BOOT;
                        imem_req <= 1'b0;
                        flush    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
